// File: rtl/bus_pirate_pkg.sv
// bus_pirate_pkg
// Shared constants for the Bus Pirate I/O engine: bus widths, pin bit
// positions, register word addresses and reset/identity values.
// Optional feature macro used by the design: BP_IRQ_EN (see bus_pirate_top).
package bus_pirate_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 6;
  localparam int NUM_PINS = 5;

  // Bit positions in every pin register
  localparam int PIN_MOSI  = 0;
  localparam int PIN_CLOCK = 1;
  localparam int PIN_MISO  = 2;
  localparam int PIN_CS    = 3;
  localparam int PIN_AUX   = 4;

  // Register word addresses
  localparam logic [ADDR_W-1:0] ADDR_ID      = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_DIR     = 6'h01;
  localparam logic [ADDR_W-1:0] ADDR_OD      = 6'h02;
  localparam logic [ADDR_W-1:0] ADDR_OUT     = 6'h03;
  localparam logic [ADDR_W-1:0] ADDR_IN      = 6'h04;
  localparam logic [ADDR_W-1:0] ADDR_LAT     = 6'h05;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 6'h06;
  localparam logic [ADDR_W-1:0] ADDR_IRQSTAT = 6'h07;
  localparam logic [ADDR_W-1:0] ADDR_SWIRQ   = 6'h08;
  localparam logic [ADDR_W-1:0] ADDR_SRAMCTL = 6'h09;
  localparam logic [ADDR_W-1:0] ADDR_SRAMIN  = 6'h0A;

  localparam logic [DATA_W-1:0] ID_VALUE    = 16'hB500;
  // Both SRAM chip selects deasserted (active-low) out of reset
  localparam logic [DATA_W-1:0] SRAMCTL_RST = 16'h0003;

endpackage

// File: rtl/bus_pirate_bp_iobuf.sv
// bp_iobuf
// Control for one 74LVC-buffered I/O pin plus a 2-flop input synchronizer.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   dir, od, out  pin configuration: 1 = output, 1 = open-drain, output value
//   bufdir        buffer direction, 1 = FPGA drives the pin
//   bufod         open-drain flag passed to the buffer
//   pin_in        bufio synchronized to clk (2-cycle latency)
//   bufio         buffer data line
module bp_iobuf (
  input  logic clk,
  input  logic rst,
  input  logic dir,
  input  logic od,
  input  logic out,
  output logic bufdir,
  output logic bufod,
  output logic pin_in,
  inout  wire  bufio
);

  logic drive_en;
  logic drive_val;
  logic sync_1;

  // Open-drain only ever pulls low; a high output releases the line.
  always_comb begin
    drive_en  = dir & (~od | ~out);
    drive_val = od ? 1'b0 : out;
  end

  assign bufio  = drive_en ? drive_val : 1'bz;
  assign bufdir = drive_en;
  assign bufod  = od;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= 1'b0;
      pin_in <= 1'b0;
    end else begin
      sync_1 <= bufio;
      pin_in <= sync_1;
    end
  end

endmodule

// File: rtl/bus_pirate_top.sv
// bus_pirate_top
// FPGA top level of the Bus Pirate I/O engine. An MCU reaches a 16-bit
// register file over an asynchronous SRAM-style bus; registers drive five
// buffered I/O pins, an 8-bit latch, two interrupts and bit-banged control
// of two quad-SPI SRAMs.
// Build option: define BP_IRQ_EN to include IRQMASK/IRQSTAT/SWIRQ; without
// it irq0/irq1 are tied low and addresses 0x06-0x08 read as zero.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   bufdir_*/bufod_*/bufio_*      per-pin buffer direction, open-drain, data
//   lat, lat_oe                   latch data, active-low latch output enable
//   mc_ce, mc_oe, mc_we           MCU bus strobes, active-low
//   mc_add, mc_data               MCU register address and data
//   irq0, irq1                    pin interrupt and software interrupt
//   sram_clock, sram0_cs/sram1_cs shared SRAM clock, active-low selects
//   sram0_sio, sram1_sio          SRAM quad data lines
module bus_pirate_top
  import bus_pirate_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              bufdir_mosi,
  output logic              bufod_mosi,
  inout  wire               bufio_mosi,
  output logic              bufdir_clock,
  output logic              bufod_clock,
  inout  wire               bufio_clock,
  output logic              bufdir_miso,
  output logic              bufod_miso,
  inout  wire               bufio_miso,
  output logic              bufdir_cs,
  output logic              bufod_cs,
  inout  wire               bufio_cs,
  output logic              bufdir_aux,
  output logic              bufod_aux,
  inout  wire               bufio_aux,
  output logic [7:0]        lat,
  output logic              lat_oe,
  input  logic              mc_ce,
  input  logic              mc_oe,
  input  logic              mc_we,
  input  logic [ADDR_W-1:0] mc_add,
  inout  wire  [DATA_W-1:0] mc_data,
  output logic              irq0,
  output logic              irq1,
  output logic              sram_clock,
  output logic              sram0_cs,
  output logic              sram1_cs,
  inout  wire  [3:0]        sram0_sio,
  inout  wire  [3:0]        sram1_sio
);

  logic [NUM_PINS-1:0] pin_dir;
  logic [NUM_PINS-1:0] pin_od;
  logic [NUM_PINS-1:0] pin_out;
  logic [NUM_PINS-1:0] pin_in;
  logic [8:0]          lat_reg;
  logic [DATA_W-1:0]   sram_ctl;
  logic [7:0]          sram_in_s1;
  logic [7:0]          sram_in;
  logic                wr_s1;
  logic                wr_s2;
  logic                wr_s3;
  logic                wr_pulse;
  logic                rd_en;
  logic [DATA_W-1:0]   rd_data;

  // ---------------------------------------------------------------- pins
  bp_iobuf u_mosi (
    .clk(clk), .rst(rst),
    .dir(pin_dir[PIN_MOSI]), .od(pin_od[PIN_MOSI]), .out(pin_out[PIN_MOSI]),
    .bufdir(bufdir_mosi), .bufod(bufod_mosi), .pin_in(pin_in[PIN_MOSI]),
    .bufio(bufio_mosi)
  );

  bp_iobuf u_clock (
    .clk(clk), .rst(rst),
    .dir(pin_dir[PIN_CLOCK]), .od(pin_od[PIN_CLOCK]), .out(pin_out[PIN_CLOCK]),
    .bufdir(bufdir_clock), .bufod(bufod_clock), .pin_in(pin_in[PIN_CLOCK]),
    .bufio(bufio_clock)
  );

  bp_iobuf u_miso (
    .clk(clk), .rst(rst),
    .dir(pin_dir[PIN_MISO]), .od(pin_od[PIN_MISO]), .out(pin_out[PIN_MISO]),
    .bufdir(bufdir_miso), .bufod(bufod_miso), .pin_in(pin_in[PIN_MISO]),
    .bufio(bufio_miso)
  );

  bp_iobuf u_cs (
    .clk(clk), .rst(rst),
    .dir(pin_dir[PIN_CS]), .od(pin_od[PIN_CS]), .out(pin_out[PIN_CS]),
    .bufdir(bufdir_cs), .bufod(bufod_cs), .pin_in(pin_in[PIN_CS]),
    .bufio(bufio_cs)
  );

  bp_iobuf u_aux (
    .clk(clk), .rst(rst),
    .dir(pin_dir[PIN_AUX]), .od(pin_od[PIN_AUX]), .out(pin_out[PIN_AUX]),
    .bufdir(bufdir_aux), .bufod(bufod_aux), .pin_in(pin_in[PIN_AUX]),
    .bufio(bufio_aux)
  );

  // ------------------------------------------------------------ write path
  // The strobe is asynchronous to clk. The write fires on the synchronized
  // rising edge, i.e. on the 3rd clk edge after ce/we fall; the MCU still
  // holds address and data stable at that point, so they are sampled
  // straight off the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_s1 <= 1'b0;
      wr_s2 <= 1'b0;
      wr_s3 <= 1'b0;
    end else begin
      wr_s1 <= ~mc_ce & ~mc_we;
      wr_s2 <= wr_s1;
      wr_s3 <= wr_s2;
    end
  end

  assign wr_pulse = wr_s2 & ~wr_s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pin_dir  <= '0;
      pin_od   <= '0;
      pin_out  <= '0;
      lat_reg  <= '0;
      sram_ctl <= SRAMCTL_RST;
    end else if (wr_pulse) begin
      case (mc_add)
        ADDR_DIR:     pin_dir  <= mc_data[NUM_PINS-1:0];
        ADDR_OD:      pin_od   <= mc_data[NUM_PINS-1:0];
        ADDR_OUT:     pin_out  <= mc_data[NUM_PINS-1:0];
        ADDR_LAT:     lat_reg  <= mc_data[8:0];
        ADDR_SRAMCTL: sram_ctl <= mc_data;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------- SRAM / latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_in_s1 <= '0;
      sram_in    <= '0;
    end else begin
      sram_in_s1 <= {sram1_sio, sram0_sio};
      sram_in    <= sram_in_s1;
    end
  end

  assign sram0_cs   = sram_ctl[0];
  assign sram1_cs   = sram_ctl[1];
  assign sram_clock = sram_ctl[2];
  assign sram0_sio  = sram_ctl[3] ? sram_ctl[7:4] : 4'bz;
  assign sram1_sio  = sram_ctl[3] ? sram_ctl[7:4] : 4'bz;

  assign lat    = lat_reg[7:0];
  assign lat_oe = ~lat_reg[8];

  // ------------------------------------------------------------ interrupts
`ifdef BP_IRQ_EN
  logic [NUM_PINS-1:0] irq_mask;
  logic [NUM_PINS-1:0] irq_stat;
  logic [NUM_PINS-1:0] in_prev;
  logic [NUM_PINS-1:0] irq_set;
  logic [NUM_PINS-1:0] irq_clr;
  logic                sw_irq;

  always_comb begin
    irq_set = pin_in & ~in_prev & irq_mask;
    irq_clr = '0;
    if (wr_pulse && (mc_add == ADDR_IRQSTAT)) irq_clr = mc_data[NUM_PINS-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_mask <= '0;
      irq_stat <= '0;
      in_prev  <= '0;
      sw_irq   <= 1'b0;
      irq0     <= 1'b0;
    end else begin
      in_prev  <= pin_in;
      // A new edge beats a same-cycle W1C so no event is lost
      irq_stat <= (irq_stat & ~irq_clr) | irq_set;
      irq0     <= |(irq_stat & irq_mask);
      if (wr_pulse && (mc_add == ADDR_IRQMASK)) irq_mask <= mc_data[NUM_PINS-1:0];
      if (wr_pulse && (mc_add == ADDR_SWIRQ))   sw_irq   <= mc_data[0];
    end
  end

  assign irq1 = sw_irq;
`else
  assign irq0 = 1'b0;
  assign irq1 = 1'b0;
`endif

  // ------------------------------------------------------------- read path
  assign rd_en = ~mc_ce & ~mc_oe & mc_we;

  always_comb begin
    rd_data = '0;
    case (mc_add)
      ADDR_ID:      rd_data = ID_VALUE;
      ADDR_DIR:     rd_data[NUM_PINS-1:0] = pin_dir;
      ADDR_OD:      rd_data[NUM_PINS-1:0] = pin_od;
      ADDR_OUT:     rd_data[NUM_PINS-1:0] = pin_out;
      ADDR_IN:      rd_data[NUM_PINS-1:0] = pin_in;
      ADDR_LAT:     rd_data[8:0] = lat_reg;
`ifdef BP_IRQ_EN
      ADDR_IRQMASK: rd_data[NUM_PINS-1:0] = irq_mask;
      ADDR_IRQSTAT: rd_data[NUM_PINS-1:0] = irq_stat;
      ADDR_SWIRQ:   rd_data[0] = sw_irq;
`endif
      ADDR_SRAMCTL: rd_data = sram_ctl;
      ADDR_SRAMIN:  rd_data[7:0] = sram_in;
      default: ;
    endcase
  end

  assign mc_data = rd_en ? rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_pirate_top.sv
// Directed testbench for bus_pirate_top. External pullups model the board so
// a released bufio line reads 1; miso and the SRAM sio buses can also be
// driven from here.
module tb_bus_pirate_top;

  logic        clk;
  logic        rst;
  logic        mc_ce, mc_oe, mc_we;
  logic [5:0]  mc_add;
  logic [15:0] tb_wdata;
  logic        tb_drv;
  logic        tb_miso_en, tb_miso_val;
  logic        tb_sio_en;

  wire         bufio_mosi, bufio_clock, bufio_miso, bufio_cs, bufio_aux;
  wire  [15:0] mc_data;
  wire  [3:0]  sram0_sio, sram1_sio;
  logic        bufdir_mosi, bufod_mosi, bufdir_clock, bufod_clock;
  logic        bufdir_miso, bufod_miso, bufdir_cs, bufod_cs;
  logic        bufdir_aux, bufod_aux;
  logic [7:0]  lat;
  logic        lat_oe, irq0, irq1, sram_clock, sram0_cs, sram1_cs;

  int          n_pass;
  int          n_total;
  logic [15:0] rd;
  int          cyc;

  pullup (bufio_mosi);
  pullup (bufio_clock);
  pullup (bufio_miso);
  pullup (bufio_cs);
  pullup (bufio_aux);

  assign mc_data    = tb_drv ? tb_wdata : 16'bz;
  assign bufio_miso = tb_miso_en ? tb_miso_val : 1'bz;
  assign sram0_sio  = tb_sio_en ? 4'h5 : 4'bz;
  assign sram1_sio  = tb_sio_en ? 4'h3 : 4'bz;

  bus_pirate_top dut (
    .clk(clk), .rst(rst),
    .bufdir_mosi(bufdir_mosi), .bufod_mosi(bufod_mosi), .bufio_mosi(bufio_mosi),
    .bufdir_clock(bufdir_clock), .bufod_clock(bufod_clock), .bufio_clock(bufio_clock),
    .bufdir_miso(bufdir_miso), .bufod_miso(bufod_miso), .bufio_miso(bufio_miso),
    .bufdir_cs(bufdir_cs), .bufod_cs(bufod_cs), .bufio_cs(bufio_cs),
    .bufdir_aux(bufdir_aux), .bufod_aux(bufod_aux), .bufio_aux(bufio_aux),
    .lat(lat), .lat_oe(lat_oe),
    .mc_ce(mc_ce), .mc_oe(mc_oe), .mc_we(mc_we),
    .mc_add(mc_add), .mc_data(mc_data),
    .irq0(irq0), .irq1(irq1),
    .sram_clock(sram_clock), .sram0_cs(sram0_cs), .sram1_cs(sram1_cs),
    .sram0_sio(sram0_sio), .sram1_sio(sram1_sio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    mc_add = a; tb_wdata = d; tb_drv = 1'b1; mc_ce = 1'b0; mc_we = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    mc_ce = 1'b1; mc_we = 1'b1; tb_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [15:0] d);
    @(negedge clk);
    mc_add = a; mc_ce = 1'b0; mc_oe = 1'b0;
    #2;
    d = mc_data;
    mc_ce = 1'b1; mc_oe = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    mc_ce = 1'b1; mc_oe = 1'b1; mc_we = 1'b1; mc_add = '0;
    tb_wdata = '0; tb_drv = 1'b0;
    tb_miso_en = 1'b1; tb_miso_val = 1'b0; tb_sio_en = 1'b0;
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_lat_oe", {15'd0, lat_oe}, 16'd1);
    check("rst_lat", {8'd0, lat}, 16'd0);
    check("rst_sram_cs", {14'd0, sram1_cs, sram0_cs}, 16'h0003);
    check("rst_sram_clock", {15'd0, sram_clock}, 16'd0);
    check("rst_bufdir", {11'd0, bufdir_aux, bufdir_cs, bufdir_miso, bufdir_clock, bufdir_mosi}, 16'd0);
    check("rst_bufod", {11'd0, bufod_aux, bufod_cs, bufod_miso, bufod_clock, bufod_mosi}, 16'd0);
    check("rst_irq", {14'd0, irq1, irq0}, 16'd0);
    check("rst_bufio_aux_released", {15'd0, bufio_aux}, 16'd1);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);

    bus_read(6'h00, rd); check("rd_id", rd, 16'hB500);
    // All pins released and pulled up except miso held low
    bus_read(6'h04, rd); check("rd_in_idle", rd, 16'h001B);
    bus_read(6'h09, rd); check("rd_sramctl_rst", rd, 16'h0003);
    bus_read(6'h3F, rd); check("rd_unlisted", rd, 16'h0000);

    // Push-pull aux
    bus_write(6'h01, 16'h0010);
    bus_write(6'h03, 16'h0010);
    check("aux_bufdir", {15'd0, bufdir_aux}, 16'd1);
    check("aux_bufio_hi", {15'd0, bufio_aux}, 16'd1);
    bus_write(6'h03, 16'h0000);
    check("aux_bufio_lo", {15'd0, bufio_aux}, 16'd0);
    check("aux_bufod", {15'd0, bufod_aux}, 16'd0);

    // Open-drain mosi
    bus_write(6'h02, 16'h0001);
    bus_write(6'h01, 16'h0001);
    bus_write(6'h03, 16'h0000);
    check("od_bufdir_drive", {15'd0, bufdir_mosi}, 16'd1);
    check("od_bufio_low", {15'd0, bufio_mosi}, 16'd0);
    check("od_bufod", {15'd0, bufod_mosi}, 16'd1);
    bus_write(6'h03, 16'h0001);
    check("od_bufdir_release", {15'd0, bufdir_mosi}, 16'd0);
    check("od_bufio_released", {15'd0, bufio_mosi}, 16'd1);
    check("aux_released", {16'd0, bufdir_aux}, 16'd0);
    bus_read(6'h01, rd); check("rd_dir", rd, 16'h0001);
    bus_read(6'h02, rd); check("rd_od", rd, 16'h0001);

    // Latch
    bus_write(6'h05, 16'h01A5);
    check("lat_val", {8'd0, lat}, 16'h00A5);
    check("lat_oe_on", {15'd0, lat_oe}, 16'd0);
    bus_read(6'h05, rd); check("rd_lat", rd, 16'h01A5);

    // Write lands exactly on the 3rd edge after the strobe falls
    @(negedge clk);
    mc_add = 6'h05; tb_wdata = 16'h0033; tb_drv = 1'b1; mc_ce = 1'b0; mc_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("wr_edge2_not_yet", {8'd0, lat}, 16'h00A5);
    @(posedge clk);
    #1 check("wr_edge3_done", {8'd0, lat}, 16'h0033);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mc_ce = 1'b1; mc_we = 1'b1; tb_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("wr_once_latoe", {15'd0, lat_oe}, 16'd1);

    // Read-only and unlisted registers ignore writes
    bus_write(6'h04, 16'hFFFF);
    bus_read(6'h04, rd); check("in_readonly", rd, 16'h001B);
    bus_write(6'h3F, 16'hFFFF);
    bus_read(6'h3F, rd); check("unlisted_wr_ignored", rd, 16'h0000);

`ifdef BP_IRQ_EN
    bus_write(6'h06, 16'h0004);
    @(negedge clk); tb_miso_val = 1'b1;
    cyc = 0;
    while (irq0 !== 1'b1 && cyc < 8) begin
      @(posedge clk); #1; cyc++;
    end
    check("irq0_set", {15'd0, irq0}, 16'd1);
    check("irq0_latency", cyc[15:0], 16'd4);
    bus_read(6'h07, rd); check("rd_irqstat", rd, 16'h0004);
    bus_write(6'h07, 16'h0004);
    check("irq0_cleared", {15'd0, irq0}, 16'd0);
    bus_read(6'h07, rd); check("irqstat_cleared", rd, 16'h0000);
    bus_write(6'h08, 16'h0001);
    check("irq1_sw", {15'd0, irq1}, 16'd1);
`else
    bus_write(6'h06, 16'h0004);
    @(negedge clk); tb_miso_val = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("irq0_tied", {15'd0, irq0}, 16'd0);
    bus_read(6'h06, rd); check("rd_irqmask_absent", rd, 16'h0000);
    bus_write(6'h08, 16'h0001);
    check("irq1_tied", {15'd0, irq1}, 16'd0);
`endif

    // SRAM bit-bang
    bus_write(6'h09, 16'h00A8);
    check("sio0_drive", {12'd0, sram0_sio}, 16'h000A);
    check("sio1_drive", {12'd0, sram1_sio}, 16'h000A);
    check("sram_cs_low", {14'd0, sram1_cs, sram0_cs}, 16'h0000);
    bus_write(6'h09, 16'h0004);
    check("sram_clock_hi", {15'd0, sram_clock}, 16'd1);
    tb_sio_en = 1'b1;
    repeat (3) @(posedge clk);
    bus_read(6'h0A, rd); check("rd_sramin", rd, 16'h0035);
    tb_sio_en = 1'b0;

    // Reset in the middle of a write strobe aborts it
    @(negedge clk);
    mc_add = 6'h05; tb_wdata = 16'h0177; tb_drv = 1'b1; mc_ce = 1'b0; mc_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2 mc_ce = 1'b1; mc_we = 1'b1; tb_drv = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_lat", {8'd0, lat}, 16'h0000);
    check("abort_lat_oe", {15'd0, lat_oe}, 16'd1);
    check("abort_sram_cs", {14'd0, sram1_cs, sram0_cs}, 16'h0003);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
